// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: ALU codes, FSM state encoding and opcode/funct constants for the multi-cycle MIPS controller
// The IMMLEX state exists only when MC_IMM_LOGIC_EN is defined.
package mc_controller_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, BNEEX, ADDIEX, ADDIWB, JEX
`ifdef MC_IMM_LOGIC_EN
    , IMMLEX
`endif
  } mc_state_t;
endpackage

// File: rtl/mc_controller_alu_dec.sv
// mc_alu_dec: maps the FSM's aluop request plus op/funct to an ALU control code
// aluop: 00 add, 01 sub, 10 R-type funct, 11 immediate logic (ANDI/ORI).
module mc_alu_dec
  import mc_controller_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic [1:0]     aluop,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  output logic [2:0]     alucont,
  output logic           bad_funct
);
  logic [2:0] f_alu;
  logic       f_bad;
  logic [2:0] i_alu;
  // R-type funct decode; unsupported funct falls back to ADD and flags itself
  always_comb begin
    f_alu = ALU_ADD;
    f_bad = 1'b0;
    case (funct)
      FN_ADD:  f_alu = ALU_ADD;
      FN_SUB:  f_alu = ALU_SUB;
      FN_AND:  f_alu = ALU_AND;
      FN_OR:   f_alu = ALU_OR;
      FN_SLT:  f_alu = ALU_SLT;
      default: f_bad = 1'b1;
    endcase
  end
  assign i_alu     = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
  assign alucont   = (aluop == 2'b00) ? ALU_ADD : (aluop == 2'b01) ? ALU_SUB :
                     (aluop == 2'b10) ? f_alu : i_alu;
  assign bad_funct = (aluop == 2'b10) & f_bad;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the shared multi-cycle MIPS datapath
// Define MC_IMM_LOGIC_EN to add ANDI/ORI via the IMMLEX state; otherwise they decode as illegal.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           pcen,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           immzext,
  output logic [2:0]     alucont,
  output logic           illegal
);
  mc_state_t  state_q, state_d;
  logic       pcwrite, br_eq, br_ne;
  logic       memwrite_c, irwrite_c, regwrite_c, illegal_c;
  logic [1:0] aluop;
  logic       bad_funct;
  mc_alu_dec #(.OPW(OPW), .FNW(FNW)) u_alu_dec (
    .aluop     (aluop),
    .op        (op),
    .funct     (funct),
    .alucont   (alucont),
    .bad_funct (bad_funct)
  );
  // State register; reset returns to FETCH asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end
  // Next-state and Moore output decode; unlisted outputs stay 0 and aluop 00 selects ADD
  always_comb begin
    state_d    = FETCH;
    pcwrite    = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    immzext    = 1'b0;
    aluop      = 2'b00;
    illegal_c  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = 1'b1;
        pcwrite   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                  (op == OP_RTYPE) ? RTYPEEX :
                  (op == OP_BEQ)   ? BEQEX :
                  (op == OP_BNE)   ? BNEEX :
                  (op == OP_ADDI)  ? ADDIEX :
                  (op == OP_J)     ? JEX : FETCH;
`ifdef MC_IMM_LOGIC_EN
        if (op == OP_ANDI || op == OP_ORI) state_d = IMMLEX;
`endif
        illegal_c = (state_d == FETCH);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        illegal_c = bad_funct;
        state_d   = bad_funct ? FETCH : RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        br_eq   = 1'b1;
      end
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        br_ne   = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: regwrite_c = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_IMM_LOGIC_EN
      IMMLEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        immzext = 1'b1;
        aluop   = 2'b11;
        state_d = ADDIWB;
      end
`endif
      default: state_d = FETCH;
    endcase
  end
  assign pcen     = reset_n & (pcwrite | (br_eq & zero) | (br_ne & ~zero));
  assign memwrite = reset_n & memwrite_c;
  assign irwrite  = reset_n & irwrite_c;
  assign regwrite = reset_n & regwrite_c;
  assign illegal  = reset_n & illegal_c;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized scoreboard bench for mc_controller against a per-instruction cycle model
module tb_mc_controller;
  import mc_controller_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] op = OP_LW;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, immzext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  logic [16:0] got;
  logic [16:0] q[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  localparam bit IMM_EN =
`ifdef MC_IMM_LOGIC_EN
    1'b1;
`else
    1'b0;
`endif

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .immzext(immzext), .alucont(alucont), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign got = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, immzext, alucont, illegal};

  function automatic logic [16:0] mk(input logic pe, io, mw, irw, rd, mtr, rw, asa,
                                     input logic [1:0] asb, ps, input logic iz,
                                     input logic [2:0] ac, input logic ill);
    return {pe, io, mw, irw, rd, mtr, rw, asa, asb, ps, iz, ac, ill};
  endfunction

  function automatic logic [2:0] fn_alu(input logic [5:0] f);
    return (f == FN_SUB) ? ALU_SUB : (f == FN_AND) ? ALU_AND : (f == FN_OR) ? ALU_OR :
           (f == FN_SLT) ? ALU_SLT : ALU_ADD;
  endfunction

  task automatic check(input string name, input logic [16:0] g, input logic [16:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h op=%b funct=%b zero=%b t=%0t", name, g, e, op, funct, zero, $time);
    end
  endtask

  // Monitor: every monitored cycle must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL underflow no expected entry t=%0t", $time);
      end else check("cycle", got, q.pop_front());
    end
  end

  // Model: push the full cycle sequence an instruction must produce, then run it
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    logic [16:0] dec, wb_i;
    bit r_ok;
    int n;
    n = 0;
    dec  = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,0,ALU_ADD,0);
    wb_i = mk(0,0,0,0,0,0,1,0,2'b00,2'b00,0,ALU_ADD,0);
    r_ok = (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
    q.push_back(mk(1,0,0,1,0,0,0,0,2'b01,2'b00,0,ALU_ADD,0)); n++;
    if (o == OP_LW || o == OP_SW) begin
      q.push_back(dec);
      q.push_back(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,ALU_ADD,0));
      n += 2;
      if (o == OP_LW) begin
        q.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,0,ALU_ADD,0));
        q.push_back(mk(0,0,0,0,0,1,1,0,2'b00,2'b00,0,ALU_ADD,0));
        n += 2;
      end else begin
        q.push_back(mk(0,1,1,0,0,0,0,0,2'b00,2'b00,0,ALU_ADD,0));
        n++;
      end
    end else if (o == OP_RTYPE) begin
      q.push_back(dec);
      q.push_back(mk(0,0,0,0,0,0,0,1,2'b00,2'b00,0,fn_alu(f),!r_ok));
      n += 2;
      if (r_ok) begin
        q.push_back(mk(0,0,0,0,1,0,1,0,2'b00,2'b00,0,ALU_ADD,0));
        n++;
      end
    end else if (o == OP_BEQ || o == OP_BNE) begin
      q.push_back(dec);
      q.push_back(mk((o == OP_BEQ) ? z : !z,0,0,0,0,0,0,1,2'b00,2'b01,0,ALU_SUB,0));
      n += 2;
    end else if (o == OP_ADDI) begin
      q.push_back(dec);
      q.push_back(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,0,ALU_ADD,0));
      q.push_back(wb_i);
      n += 3;
    end else if (o == OP_J) begin
      q.push_back(dec);
      q.push_back(mk(1,0,0,0,0,0,0,0,2'b00,2'b10,0,ALU_ADD,0));
      n += 2;
    end else if (IMM_EN && (o == OP_ANDI || o == OP_ORI)) begin
      q.push_back(dec);
      q.push_back(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,1,(o == OP_ANDI) ? ALU_AND : ALU_OR,0));
      q.push_back(wb_i);
      n += 3;
    end else begin
      q.push_back(mk(0,0,0,0,0,0,0,0,2'b11,2'b00,0,ALU_ADD,1));
      n++;
    end
    op = o;
    funct = f;
    zero = z;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] rst_v;
    logic [5:0] ops [9];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_ANDI, OP_ORI};
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    rst_v = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,0,ALU_ADD,0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", got, rst_v);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    issue(OP_LW, 6'd0, 1'b0);
    issue(OP_RTYPE, FN_SLT, 1'b0);
    issue(OP_RTYPE, 6'b000000, 1'b0);
    issue(OP_BEQ, 6'd0, 1'b1);
    issue(OP_BEQ, 6'd0, 1'b0);
    issue(OP_BNE, 6'd0, 1'b1);
    issue(OP_BNE, 6'd0, 1'b0);
    issue(OP_ORI, 6'd0, 1'b0);
    issue(OP_ANDI, 6'd0, 1'b1);
    issue(OP_SW, 6'd0, 1'b0);
    issue(OP_ADDI, 6'd0, 1'b0);
    issue(OP_J, 6'd0, 1'b1);
    issue(6'b111111, 6'd0, 1'b0);
    mon_en = 1'b0;
    op = OP_SW;
    repeat (3) @(posedge clk);
    #1;
    check("memwr_before_reset", got, mk(0,1,1,0,0,0,0,0,2'b00,2'b00,0,ALU_ADD,0));
    reset_n = 1'b0;
    #1;
    check("memwr_reset_abort", got, rst_v);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    issue(OP_LW, 6'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      o = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      issue(o, f, 1'($urandom));
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
